// File: rtl/register_file.sv
// 32 x 32 MIPS general-purpose register file: two asynchronous read ports,
// one synchronous write port, register 0 hardwired to zero.
module register_file #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_REGS   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] ReadReg1,
  input  logic [ADDR_WIDTH-1:0] ReadReg2,
  input  logic [ADDR_WIDTH-1:0] WriteReg,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic                  RegWrite,
  output logic [DATA_WIDTH-1:0] ReadData1,
  output logic [DATA_WIDTH-1:0] ReadData2
);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  // Next-state: single write port; writes to register 0 are dropped.
  always_comb begin
    regs_d = regs_q;
    if (RegWrite && (WriteReg != '0)) begin
      regs_d[WriteReg] = WriteData;
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  // Reads see the stored array only; no bypass of WriteData.
  always_comb begin
    ReadData1 = (ReadReg1 == '0) ? '0 : regs_q[ReadReg1];
    ReadData2 = (ReadReg2 == '0) ? '0 : regs_q[ReadReg2];
  end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: array-based reference model checked
// every cycle, plus directed vectors with literal expected values.
module tb_register_file;

  logic        clk;
  logic        rst_n;
  logic [4:0]  ReadReg1, ReadReg2, WriteReg;
  logic [31:0] WriteData;
  logic        RegWrite;
  logic [31:0] ReadData1, ReadData2;

  int vectors = 0;
  int errors  = 0;

  logic [31:0] model [32];

  register_file dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ReadReg1  (ReadReg1),
    .ReadReg2  (ReadReg2),
    .WriteReg  (WriteReg),
    .WriteData (WriteData),
    .RegWrite  (RegWrite),
    .ReadData1 (ReadData1),
    .ReadData2 (ReadData2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  end

  // Reference behaviour: reset clears everything, enabled writes to nonzero registers land.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (RegWrite && WriteReg != 5'd0) begin
      model[WriteReg] = WriteData;
    end
  end

  function automatic logic [31:0] model_read(input logic [4:0] a);
    return (a == 5'd0) ? 32'h0 : model[a];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Per-cycle compare late in the high phase, when inputs and outputs are settled.
  always @(posedge clk) begin
    #4;
    check("model_rd1", ReadData1, model_read(ReadReg1));
    check("model_rd2", ReadData2, model_read(ReadReg2));
  end

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input int n);
    @(negedge clk);
    WriteReg = a; WriteData = d; RegWrite = 1'b1;
    repeat (n) @(negedge clk);
    RegWrite = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
    ReadReg1 = a1; ReadReg2 = a2;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; RegWrite = 1'b0; WriteReg = '0; WriteData = '0;
    ReadReg1 = '0; ReadReg2 = '0;
    repeat (2) @(negedge clk);
    rd(5'd5, 5'd31);
    check("reset_rd1", ReadData1, 32'h0);
    check("reset_rd2", ReadData2, 32'h0);
    rst_n = 1'b1;

    // Basic write/read with RegWrite held across multiple edges.
    wr(5'd10, 32'd10, 2);
    wr(5'd12, 32'd12, 3);
    rd(5'd10, 5'd12);
    check("basic_r10", ReadData1, 32'd10);
    check("basic_r12", ReadData2, 32'd12);

    // Write enable gating.
    @(negedge clk);
    WriteReg = 5'd7; WriteData = 32'hDEADBEEF; RegWrite = 1'b0;
    repeat (3) @(negedge clk);
    rd(5'd7, 5'd10);
    check("gate_r7", ReadData1, 32'h0);

    // Register zero discards writes.
    wr(5'd0, 32'hFFFFFFFF, 1);
    rd(5'd0, 5'd0);
    check("zero_rd1", ReadData1, 32'h0);
    check("zero_rd2", ReadData2, 32'h0);

    // Read-during-write: old value before the edge, new value right after.
    wr(5'd3, 32'h11111111, 1);
    @(negedge clk);
    WriteReg = 5'd3; WriteData = 32'h22222222; RegWrite = 1'b1;
    rd(5'd3, 5'd3);
    check("rdw_before", ReadData1, 32'h11111111);
    @(posedge clk); #1;
    check("rdw_after", ReadData1, 32'h22222222);
    @(negedge clk);
    RegWrite = 1'b0;

    // Dual-port independence and same-address reads.
    wr(5'd31, 32'hA5A5A5A5, 1);
    wr(5'd1, 32'h5A5A5A5A, 1);
    rd(5'd31, 5'd1);
    check("dual_r31", ReadData1, 32'hA5A5A5A5);
    check("dual_r1", ReadData2, 32'h5A5A5A5A);
    rd(5'd31, 5'd31);
    check("same_rd1", ReadData1, 32'hA5A5A5A5);
    check("same_rd2", ReadData2, 32'hA5A5A5A5);

    // Mid-cycle asynchronous reset clears immediately.
    wr(5'd5, 32'hCAFEF00D, 1);
    rd(5'd5, 5'd31);
    check("pre_reset_r5", ReadData1, 32'hCAFEF00D);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_r5", ReadData1, 32'h0);
    check("async_reset_r31", ReadData2, 32'h0);

    // Writes are ignored while reset is held.
    @(negedge clk);
    WriteReg = 5'd9; WriteData = 32'h12345678; RegWrite = 1'b1;
    @(negedge clk);
    RegWrite = 1'b0;
    rd(5'd9, 5'd9);
    check("reset_blocks_wr", ReadData1, 32'h0);
    rst_n = 1'b1;

    // Reset coincident with a write edge: reset wins.
    wr(5'd4, 32'h0BADF00D, 1);
    rd(5'd4, 5'd4);
    check("pre_coinc_r4", ReadData1, 32'h0BADF00D);
    @(negedge clk);
    WriteReg = 5'd4; WriteData = 32'h77777777; RegWrite = 1'b1;
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    check("coinc_reset_r4", ReadData1, 32'h0);
    @(negedge clk);
    RegWrite = 1'b0;
    rst_n = 1'b1;

    // Post-reset writes work again.
    wr(5'd20, 32'h87654321, 1);
    rd(5'd20, 5'd4);
    check("post_reset_r20", ReadData1, 32'h87654321);
    check("post_reset_r4", ReadData2, 32'h0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
